// File: rtl/psum_fabric.sv
// Runtime-segmentable partial-sum interconnect for a ROWS x COLS PE array.
// Optional stall counter output perf_stall is built when PSUM_FABRIC_PERF_EN is defined.
module psum_fabric #(
  parameter int ROWS   = 6,
  parameter int COLS   = 7,
  parameter int PSUM_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [ROWS-2:0]               cfg_split,
  input  logic                          cfg_top_ext,
  input  logic [CNT_W-1:0]              cfg_zero_cnt,
  input  logic                          cfg_load,
  input  logic                          conv_continue,
  output logic                          cfg_busy,
  output logic                          error,
  input  logic [ROWS*COLS-1:0]          pe_out_valid,
  input  logic [ROWS*COLS*PSUM_W-1:0]   pe_out_data,
  output logic [ROWS*COLS-1:0]          pe_out_ack,
  output logic [ROWS*COLS-1:0]          pe_in_valid,
  output logic [ROWS*COLS*PSUM_W-1:0]   pe_in_data,
  input  logic [ROWS*COLS-1:0]          pe_in_ack,
  input  logic [COLS-1:0]               ext_psum_valid,
  input  logic [COLS*PSUM_W-1:0]        ext_psum_data,
  output logic [COLS-1:0]               ext_psum_ack,
  output logic [ROWS*COLS-1:0]          out_valid,
  output logic [ROWS*COLS*PSUM_W-1:0]   out_data,
  input  logic [ROWS*COLS-1:0]          out_ack
`ifdef PSUM_FABRIC_PERF_EN
  ,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int NB = ROWS - 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWITCH} state_e;

  state_e              state_q, state_d;
  logic [NB-1:0]       act_split_q, act_split_d;
  logic                act_top_ext_q, act_top_ext_d;
  logic [CNT_W-1:0]    act_zcnt_q, act_zcnt_d;
  logic [NB-1:0]       pend_split_q, pend_split_d;
  logic                pend_top_ext_q, pend_top_ext_d;
  logic [CNT_W-1:0]    pend_zcnt_q, pend_zcnt_d;
  logic                error_q, error_d;

  logic [1:0]          cnt_q [NB][COLS];
  logic [1:0]          cnt_d [NB][COLS];
  logic [PSUM_W-1:0]   e0_q  [NB][COLS];
  logic [PSUM_W-1:0]   e0_d  [NB][COLS];
  logic [PSUM_W-1:0]   e1_q  [NB][COLS];
  logic [PSUM_W-1:0]   e1_d  [NB][COLS];
  logic [CNT_W-1:0]    zcnt_q [ROWS][COLS];
  logic [CNT_W-1:0]    zcnt_d [ROWS][COLS];

  logic [ROWS-1:0]     head_v, exit_v, new_head_v;
  logic                inj_en;
  logic                drain_pend;

  assign head_v     = {act_split_q, ~act_top_ext_q};
  assign exit_v     = {1'b1, act_split_q};
  assign new_head_v = {pend_split_q, ~pend_top_ext_q};
  assign inj_en     = (state_q == ST_RUN);
  assign cfg_busy   = (state_q != ST_RUN);
  assign error      = error_q;

  // Per-link routing: exits and the external row are pure pass-through,
  // heads inject zeros, chained rows read the head of the boundary FIFO.
  always_comb begin
    int i;
    int rp;
    i            = 0;
    rp           = 0;
    pe_out_ack   = '0;
    out_valid    = '0;
    out_data     = '0;
    pe_in_valid  = '0;
    pe_in_data   = '0;
    ext_psum_ack = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        i  = r * COLS + c;
        rp = (r > 0) ? r - 1 : 0;
        if (exit_v[r]) begin
          out_valid[i]                     = pe_out_valid[i];
          out_data[i*PSUM_W +: PSUM_W]     = pe_out_data[i*PSUM_W +: PSUM_W];
          pe_out_ack[i]                    = out_ack[i];
        end else begin
          pe_out_ack[i] = (cnt_q[r][c] != 2'd2);
        end
        if (r == 0 && act_top_ext_q) begin
          pe_in_valid[i]                   = ext_psum_valid[c];
          pe_in_data[i*PSUM_W +: PSUM_W]   = ext_psum_data[c*PSUM_W +: PSUM_W];
          ext_psum_ack[c]                  = pe_in_ack[i];
        end else if (head_v[r]) begin
          pe_in_valid[i] = inj_en && (zcnt_q[r][c] != '0);
        end else begin
          pe_in_valid[i]                   = (cnt_q[rp][c] != 2'd0);
          pe_in_data[i*PSUM_W +: PSUM_W]   = e0_q[rp][c];
        end
      end
    end
  end

  // Boundary FIFOs: e0 is always the entry presented downstream.
  always_comb begin
    logic push;
    logic pop;
    push       = 1'b0;
    pop        = 1'b0;
    cnt_d      = cnt_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    drain_pend = 1'b0;
    for (int r = 0; r < NB; r++) begin
      for (int c = 0; c < COLS; c++) begin
        push = !act_split_q[r] && pe_out_valid[r*COLS+c] && (cnt_q[r][c] != 2'd2);
        pop  = !act_split_q[r] && pe_in_ack[(r+1)*COLS+c] && (cnt_q[r][c] != 2'd0);
        if ((cnt_q[r][c] != 2'd0) || (!act_split_q[r] && pe_out_valid[r*COLS+c]))
          drain_pend = 1'b1;
        case ({push, pop})
          2'b10: begin
            if (cnt_q[r][c] == 2'd0) e0_d[r][c] = pe_out_data[(r*COLS+c)*PSUM_W +: PSUM_W];
            else                     e1_d[r][c] = pe_out_data[(r*COLS+c)*PSUM_W +: PSUM_W];
            cnt_d[r][c] = cnt_q[r][c] + 2'd1;
          end
          2'b01: begin
            e0_d[r][c]  = e1_q[r][c];
            cnt_d[r][c] = cnt_q[r][c] - 2'd1;
          end
          2'b11: e0_d[r][c] = pe_out_data[(r*COLS+c)*PSUM_W +: PSUM_W];
          default: ;
        endcase
      end
    end
  end

  // Reconfiguration FSM and zero-injection counters.
  always_comb begin
    state_d        = state_q;
    act_split_d    = act_split_q;
    act_top_ext_d  = act_top_ext_q;
    act_zcnt_d     = act_zcnt_q;
    pend_split_d   = pend_split_q;
    pend_top_ext_d = pend_top_ext_q;
    pend_zcnt_d    = pend_zcnt_q;
    error_d        = cfg_load && (state_q != ST_RUN);
    zcnt_d         = zcnt_q;
    case (state_q)
      ST_RUN: begin
        if (cfg_load) begin
          pend_split_d   = cfg_split;
          pend_top_ext_d = cfg_top_ext;
          pend_zcnt_d    = cfg_zero_cnt;
          state_d        = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!drain_pend) state_d = ST_SWITCH;
      end
      ST_SWITCH: begin
        act_split_d   = pend_split_q;
        act_top_ext_d = pend_top_ext_q;
        act_zcnt_d    = pend_zcnt_q;
        state_d       = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (state_q == ST_SWITCH) begin
          zcnt_d[r][c] = new_head_v[r] ? pend_zcnt_q : '0;
        end else if (state_q == ST_RUN && conv_continue && head_v[r]) begin
          zcnt_d[r][c] = act_zcnt_q;
        end else if (head_v[r] && pe_in_valid[r*COLS+c] && pe_in_ack[r*COLS+c]) begin
          zcnt_d[r][c] = zcnt_q[r][c] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_RUN;
      act_split_q    <= '0;
      act_top_ext_q  <= 1'b0;
      act_zcnt_q     <= '0;
      pend_split_q   <= '0;
      pend_top_ext_q <= 1'b0;
      pend_zcnt_q    <= '0;
      error_q        <= 1'b0;
      cnt_q          <= '{default: 2'd0};
      zcnt_q         <= '{default: '0};
    end else begin
      state_q        <= state_d;
      act_split_q    <= act_split_d;
      act_top_ext_q  <= act_top_ext_d;
      act_zcnt_q     <= act_zcnt_d;
      pend_split_q   <= pend_split_d;
      pend_top_ext_q <= pend_top_ext_d;
      pend_zcnt_q    <= pend_zcnt_d;
      error_q        <= error_d;
      cnt_q          <= cnt_d;
      zcnt_q         <= zcnt_d;
    end
  end

  // FIFO payload needs no reset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end

`ifdef PSUM_FABRIC_PERF_EN
  logic [31:0] perf_q, perf_d;
  logic        stall_any;

  always_comb begin
    stall_any = 1'b0;
    for (int r = 0; r < NB; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (!act_split_q[r] && (cnt_q[r][c] == 2'd2) && pe_out_valid[r*COLS+c])
          stall_any = 1'b1;
      end
    end
    perf_d = perf_q;
    if (state_q == ST_SWITCH)               perf_d = '0;
    else if (stall_any && (perf_q != '1))   perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) perf_q <= '0;
    else      perf_q <= perf_d;
  end

  assign perf_stall = perf_q;
`endif

endmodule

// File: tb/tb_psum_fabric.sv
// Directed bench for psum_fabric: default 6x7x16 instance plus a 4x3x24 instance.
module tb_psum_fabric;
  localparam int R = 6, C = 7, W = 16, N = R * C;
  localparam int R2 = 4, C2 = 3, W2 = 24, N2 = R2 * C2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [R-2:0]   cfg_split = '0;
  logic           cfg_top_ext = 1'b0;
  logic [15:0]    cfg_zero_cnt = '0;
  logic           cfg_load = 1'b0, conv_continue = 1'b0;
  logic           cfg_busy, error;
  logic [N-1:0]   pe_out_valid = '0, pe_out_ack, pe_in_valid, pe_in_ack = '0;
  logic [N*W-1:0] pe_out_data = '0, pe_in_data, out_data;
  logic [C-1:0]   ext_psum_valid = '0, ext_psum_ack;
  logic [C*W-1:0] ext_psum_data = '0;
  logic [N-1:0]   out_valid, out_ack = '0;

  logic [R2-2:0]    s_cfg_split = '0;
  logic             s_cfg_top_ext = 1'b0;
  logic [15:0]      s_cfg_zero_cnt = '0;
  logic             s_cfg_load = 1'b0, s_conv_continue = 1'b0;
  logic             s_cfg_busy, s_error;
  logic [N2-1:0]    s_pe_out_valid = '0, s_pe_out_ack, s_pe_in_valid, s_pe_in_ack = '0;
  logic [N2*W2-1:0] s_pe_out_data = '0, s_pe_in_data, s_out_data;
  logic [C2-1:0]    s_ext_psum_valid = '0, s_ext_psum_ack;
  logic [C2*W2-1:0] s_ext_psum_data = '0;
  logic [N2-1:0]    s_out_valid, s_out_ack = '0;
`ifdef PSUM_FABRIC_PERF_EN
  logic [31:0] perf_stall, s_perf_stall;
`endif

  psum_fabric dut (
    .clk(clk), .rst(rst), .cfg_split(cfg_split), .cfg_top_ext(cfg_top_ext),
    .cfg_zero_cnt(cfg_zero_cnt), .cfg_load(cfg_load), .conv_continue(conv_continue),
    .cfg_busy(cfg_busy), .error(error),
    .pe_out_valid(pe_out_valid), .pe_out_data(pe_out_data), .pe_out_ack(pe_out_ack),
    .pe_in_valid(pe_in_valid), .pe_in_data(pe_in_data), .pe_in_ack(pe_in_ack),
    .ext_psum_valid(ext_psum_valid), .ext_psum_data(ext_psum_data), .ext_psum_ack(ext_psum_ack),
    .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack)
`ifdef PSUM_FABRIC_PERF_EN
    , .perf_stall(perf_stall)
`endif
  );

  psum_fabric #(.ROWS(R2), .COLS(C2), .PSUM_W(W2), .CNT_W(16)) dut_s (
    .clk(clk), .rst(rst), .cfg_split(s_cfg_split), .cfg_top_ext(s_cfg_top_ext),
    .cfg_zero_cnt(s_cfg_zero_cnt), .cfg_load(s_cfg_load), .conv_continue(s_conv_continue),
    .cfg_busy(s_cfg_busy), .error(s_error),
    .pe_out_valid(s_pe_out_valid), .pe_out_data(s_pe_out_data), .pe_out_ack(s_pe_out_ack),
    .pe_in_valid(s_pe_in_valid), .pe_in_data(s_pe_in_data), .pe_in_ack(s_pe_in_ack),
    .ext_psum_valid(s_ext_psum_valid), .ext_psum_data(s_ext_psum_data), .ext_psum_ack(s_ext_psum_ack),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_ack(s_out_ack)
`ifdef PSUM_FABRIC_PERF_EN
    , .perf_stall(s_perf_stall)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [N-1:0] rm(input int r);
    logic [N-1:0] m;
    m = '0;
    for (int c = 0; c < C; c++) m[r*C+c] = 1'b1;
    return m;
  endfunction

  function automatic logic [W-1:0] in_d(input int i);
    return pe_in_data[i*W +: W];
  endfunction

  task automatic po(input int i, input logic v, input logic [W-1:0] d);
    pe_out_valid[i]     = v;
    pe_out_data[i*W +: W] = d;
  endtask

  task automatic do_cfg(input logic [R-2:0] sp, input logic te, input logic [15:0] z);
    cfg_split    = sp;
    cfg_top_ext  = te;
    cfg_zero_cnt = z;
    cfg_load     = 1'b1;
    tick();
    cfg_load     = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (2) tick();
    chk("rst_busy", cfg_busy, 0);
    chk("rst_error", error, 0);
    chk("rst_in_valid", pe_in_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ext_ack", ext_psum_ack, 0);
    chk("rst_pe_out_ack", pe_out_ack, {N{1'b1}} ^ rm(5));
    rst = 1'b1;
    tick();

    // external top row, no splits
    do_cfg('0, 1'b1, 16'd0);
    chk("cfg1_busy_drain", cfg_busy, 1);
    tick();
    chk("cfg1_busy_switch", cfg_busy, 1);
    tick();
    chk("cfg1_busy_run", cfg_busy, 0);

    ext_psum_valid[2] = 1'b1;
    ext_psum_data[2*W +: W] = 16'd5;
    pe_in_ack[2] = 1'b1;
    #1;
    chk("ext_in_valid", pe_in_valid, 64'd1 << 2);
    chk("ext_in_data", in_d(2), 16'd5);
    chk("ext_ack", ext_psum_ack, 7'b0000100);
    ext_psum_valid = '0;
    pe_in_ack = '0;

    po(2, 1'b1, 16'd5);
    #1;
    chk("chain_push_ack", pe_out_ack[2], 1);
    chk("chain_not_yet", pe_in_valid[9], 0);
    chk("chain_no_exit", out_valid, 0);
    tick();
    po(2, 1'b0, 16'd0);
    #1;
    chk("chain_valid_next", pe_in_valid[9], 1);
    chk("chain_data", in_d(9), 16'd5);
    pe_in_ack[9] = 1'b1;
    tick();
    pe_in_ack[9] = 1'b0;
    chk("chain_popped", pe_in_valid, 0);

    po(38, 1'b1, 16'hABCD);
    out_ack[38] = 1'b1;
    #1;
    chk("exit_valid", out_valid, 64'd1 << 38);
    chk("exit_data", out_data[38*W +: W], 16'hABCD);
    chk("exit_ack_hi", pe_out_ack[38], 1);
    out_ack[38] = 1'b0;
    #1;
    chk("exit_ack_lo", pe_out_ack[38], 0);
    po(38, 1'b0, 16'd0);

    // back-pressure on row0->row1 col0
    po(0, 1'b1, 16'h11);
    #1;
    chk("bp_ack1", pe_out_ack[0], 1);
    tick();
    po(0, 1'b1, 16'h22);
    #1;
    chk("bp_ack2", pe_out_ack[0], 1);
    chk("bp_head11", in_d(7), 16'h11);
    tick();
    po(0, 1'b1, 16'h33);
    #1;
    chk("bp_full", pe_out_ack[0], 0);
    tick();
    tick();
    pe_in_ack[7] = 1'b1;
    #1;
    chk("bp_rel_data11", in_d(7), 16'h11);
    chk("bp_rel_still_full", pe_out_ack[0], 0);
    tick();
    chk("bp_ack3", pe_out_ack[0], 1);
    chk("bp_data22", in_d(7), 16'h22);
    tick();
    po(0, 1'b0, 16'd0);
    #1;
    chk("bp_valid33", pe_in_valid[7], 1);
    chk("bp_data33", in_d(7), 16'h33);
    tick();
    chk("bp_empty", pe_in_valid[7], 0);
    pe_in_ack = '0;
`ifdef PSUM_FABRIC_PERF_EN
    chk("perf_stall", perf_stall, 32'd3);
`endif

    // split below row 2, zero-injected heads at rows 0 and 3
    do_cfg(5'b00100, 1'b0, 16'd3);
    chk("cfg2_busy", cfg_busy, 1);
    tick();
    tick();
    chk("cfg2_run", cfg_busy, 0);
    pe_in_ack = '1;
    #1;
    chk("zero_v0", pe_in_valid, rm(0) | rm(3));
    chk("zero_data", in_d(3*C+4), 16'd0);
    tick();
    chk("zero_v1", pe_in_valid, rm(0) | rm(3));
    tick();
    chk("zero_v2", pe_in_valid, rm(0) | rm(3));
    tick();
    chk("zero_done", pe_in_valid, 0);
    pe_out_valid = '1;
    ext_psum_valid = '1;
    #1;
    chk("split_exits", out_valid, rm(2) | rm(5));
    chk("split_ext_ack", ext_psum_ack, 0);
    pe_out_valid = '0;
    ext_psum_valid = '0;
    conv_continue = 1'b1;
    tick();
    conv_continue = 1'b0;
    chk("cont_v0", pe_in_valid, rm(0) | rm(3));
    tick();
    tick();
    chk("cont_v2", pe_in_valid, rm(0) | rm(3));
    tick();
    chk("cont_done", pe_in_valid, 0);

    // reconfiguration with a full FIFO
    pe_in_ack = '0;
    conv_continue = 1'b1;
    tick();
    conv_continue = 1'b0;
    po(1, 1'b1, 16'h41);
    tick();
    po(1, 1'b1, 16'h42);
    tick();
    po(1, 1'b0, 16'd0);
    #1;
    chk("rc_pre_valid", pe_in_valid, rm(0) | rm(3) | (64'd1 << 8));
    chk("rc_pre_data", in_d(8), 16'h41);
    chk("rc_pre_full", pe_out_ack[1], 0);
    do_cfg(5'b00001, 1'b0, 16'd2);
    chk("rc_busy", cfg_busy, 1);
    chk("rc_frozen", pe_in_valid, 64'd1 << 8);
    do_cfg(5'b10000, 1'b1, 16'd7);
    chk("rc_error", error, 1);
    chk("rc_busy2", cfg_busy, 1);
    pe_in_ack[8] = 1'b1;
    #1;
    chk("rc_drain41", in_d(8), 16'h41);
    tick();
    chk("rc_error_pulse", error, 0);
    chk("rc_drain42", in_d(8), 16'h42);
    tick();
    pe_in_ack[8] = 1'b0;
    chk("rc_still_drain", cfg_busy, 1);
    tick();
    chk("rc_switch", cfg_busy, 1);
    tick();
    chk("rc_run", cfg_busy, 0);
    chk("rc_new_heads", pe_in_valid, rm(0) | rm(1));
    pe_out_valid = '1;
    #1;
    chk("rc_new_exits", out_valid, rm(0) | rm(5));
    pe_out_valid = '0;
    pe_in_ack = '1;
    tick();
    chk("rc_z1", pe_in_valid, rm(0) | rm(1));
    tick();
    chk("rc_z0", pe_in_valid, 0);

    // reset with occupied FIFO and zcnt=2
    pe_in_ack = '0;
    conv_continue = 1'b1;
    tick();
    conv_continue = 1'b0;
    po(7, 1'b1, 16'h77);
    tick();
    po(7, 1'b1, 16'h78);
    tick();
    #1;
    chk("mr_full", pe_out_ack[7], 0);
    chk("mr_pre_valid", pe_in_valid, rm(0) | rm(1) | (64'd1 << 14));
    rst = 1'b0;
    po(7, 1'b0, 16'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("mr_in_valid", pe_in_valid, 0);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_busy", cfg_busy, 0);
    chk("mr_error", error, 0);
    chk("mr_fifo_empty", pe_out_ack[7], 1);
    conv_continue = 1'b1;
    tick();
    conv_continue = 1'b0;
    chk("mr_no_inject", pe_in_valid, 0);

    // 4x3 instance, 24-bit psums, split below row 0
    s_cfg_split    = 3'b001;
    s_cfg_top_ext  = 1'b0;
    s_cfg_zero_cnt = 16'd1;
    s_cfg_load     = 1'b1;
    tick();
    s_cfg_load     = 1'b0;
    tick();
    tick();
    chk("s_heads", s_pe_in_valid, 12'h03F);
    s_pe_out_valid[5] = 1'b1;
    s_pe_out_data[5*W2 +: W2] = 24'hFFFFFF;
    #1;
    chk("s_push_ack", s_pe_out_ack[5], 1);
    tick();
    s_pe_out_valid[5] = 1'b0;
    #1;
    chk("s_chain_valid", s_pe_in_valid[8], 1);
    chk("s_chain_data", s_pe_in_data[8*W2 +: W2], 24'hFFFFFF);
    s_pe_out_valid[1] = 1'b1;
    s_pe_out_data[1*W2 +: W2] = 24'h800001;
    s_out_ack[1] = 1'b1;
    #1;
    chk("s_exit_valid", s_out_valid, 12'h002);
    chk("s_exit_data", s_out_data[1*W2 +: W2], 24'h800001);
    chk("s_exit_ack", s_pe_out_ack[1], 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
